// File: rtl/tinymos6502_pkg.sv
// rtl/tinymos6502_pkg.sv - shared types, vector defaults and output decode for the interrupt sequencer
package tinymos6502_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DUM1,
        ST_DUM2,
        ST_PCH,
        ST_PCL,
        ST_PSR,
        ST_VLO,
        ST_VHI
    } seq_state_t;

    typedef enum logic [1:0] {
        KIND_RST,
        KIND_NMI,
        KIND_BRK,
        KIND_IRQ
    } seq_kind_t;

    localparam logic [15:0] DEF_NMI_VEC = 16'hFFFA;
    localparam logic [15:0] DEF_RST_VEC = 16'hFFFC;
    localparam logic [15:0] DEF_IRQ_VEC = 16'hFFFE;

    typedef struct packed {
        logic        busy;
        logic        push_pch;
        logic        push_pcl;
        logic        push_p;
        logic        sp_dec;
        logic        rw;
        logic        b_flag;
        logic        vec_rd_lo;
        logic        vec_rd_hi;
        logic        set_i;
        logic [15:0] vec_addr;
    } seq_out_t;

    // Output levels for a state; a reset sequence walks the stack without writing it.
    function automatic seq_out_t decode_outputs(seq_state_t st, seq_kind_t kind, logic [15:0] vec);
        seq_out_t o;
        logic     is_rst;
        is_rst = (kind == KIND_RST);
        o      = '0;
        o.rw   = 1'b1;
        if (st != ST_IDLE) begin
            o.busy   = 1'b1;
            o.b_flag = (kind == KIND_BRK);
        end
        case (st)
            ST_PCH, ST_PCL, ST_PSR: begin
                o.sp_dec   = 1'b1;
                o.rw       = is_rst;
                o.push_pch = !is_rst && (st == ST_PCH);
                o.push_pcl = !is_rst && (st == ST_PCL);
                o.push_p   = !is_rst && (st == ST_PSR);
            end
            ST_VLO: begin
                o.vec_rd_lo = 1'b1;
                o.vec_addr  = vec;
            end
            ST_VHI: begin
                o.vec_rd_hi = 1'b1;
                o.vec_addr  = vec + 16'd1;
                o.set_i     = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// rtl/interrupt_sequencer_if.sv - decoder/bus-side signal bundle of the interrupt sequencer
interface interrupt_sequencer_if;
    logic        rdy;
    logic        nmi;
    logic        irq;
    logic        i_flag;
    logic        insn_boundary;
    logic        brk;
    logic        busy;
    logic        push_pch;
    logic        push_pcl;
    logic        push_p;
    logic        sp_dec;
    logic        rw;
    logic        b_flag;
    logic        vec_rd_lo;
    logic        vec_rd_hi;
    logic [15:0] vec_addr;
    logic        set_i;
    logic        done;

    modport master (
        output rdy, nmi, irq, i_flag, insn_boundary, brk,
        input  busy, push_pch, push_pcl, push_p, sp_dec, rw, b_flag,
               vec_rd_lo, vec_rd_hi, vec_addr, set_i, done
    );

    modport slave (
        input  rdy, nmi, irq, i_flag, insn_boundary, brk,
        output busy, push_pch, push_pcl, push_p, sp_dec, rw, b_flag,
               vec_rd_lo, vec_rd_hi, vec_addr, set_i, done
    );
endinterface

// File: rtl/nmi_edge_detect.sv
// rtl/nmi_edge_detect.sv - falling-edge detector and request latch for the active-low NMI pin
module nmi_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic nmi,
    input  logic clear,
    output logic pending
);
    logic nmi_q;
    logic latched;
    logic fall;

    assign fall    = nmi_q & ~nmi;
    assign pending = latched | fall;

    // The pin is tracked through reset so a level held low across reset is not seen as an edge.
    always_ff @(posedge clk) begin
        nmi_q <= nmi;
        if (!rst_n) begin
            latched <= 1'b0;
        end else begin
            latched <= clear ? 1'b0 : pending;
        end
    end
endmodule

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - 7-cycle reset/NMI/BRK/IRQ entry sequencer with NMI hijack
module interrupt_sequencer
    import tinymos6502_pkg::*;
#(
    parameter logic [15:0] NMI_VEC = DEF_NMI_VEC,
    parameter logic [15:0] RST_VEC = DEF_RST_VEC,
    parameter logic [15:0] IRQ_VEC = DEF_IRQ_VEC
) (
    input logic            clk,
    input logic            rst_n,
    interrupt_sequencer_if.slave bus
);
    seq_state_t  state;
    seq_state_t  state_nx;
    seq_kind_t   kind;
    seq_kind_t   kind_nx;
    logic        vec_sel_nmi;
    logic        vec_sel_nmi_nx;
    logic        rst_pending;
    logic        nmi_pending;
    logic        nmi_clear;
    logic [15:0] vec_nx;
    seq_out_t    outs;

    nmi_edge_detect u_nmi (
        .clk     (clk),
        .rst_n   (rst_n),
        .nmi     (bus.nmi),
        .clear   (nmi_clear),
        .pending (nmi_pending)
    );

    always_comb begin
        state_nx       = state;
        kind_nx        = kind;
        vec_sel_nmi_nx = vec_sel_nmi;
        nmi_clear      = 1'b0;
        case (state)
            ST_IDLE: begin
                vec_sel_nmi_nx = 1'b0;
                if (bus.rdy) begin
                    if (rst_pending) begin
                        state_nx = ST_DUM1;
                        kind_nx  = KIND_RST;
                    end else if (bus.insn_boundary) begin
                        if (nmi_pending) begin
                            state_nx = ST_DUM1;
                            kind_nx  = KIND_NMI;
                        end else if (bus.brk) begin
                            state_nx = ST_DUM1;
                            kind_nx  = KIND_BRK;
                        end else if (!bus.irq && !bus.i_flag) begin
                            state_nx = ST_DUM1;
                            kind_nx  = KIND_IRQ;
                        end
                    end
                end
            end
            ST_DUM1: if (bus.rdy) state_nx = ST_DUM2;
            ST_DUM2: if (bus.rdy) state_nx = ST_PCH;
            ST_PCH:  state_nx = ST_PCL;
            ST_PCL:  state_nx = ST_PSR;
            ST_PSR: begin
                state_nx = ST_VLO;
                // An NMI raised while an IRQ/BRK frame is being pushed takes over its vector fetch.
                if (kind == KIND_NMI) begin
                    nmi_clear = 1'b1;
                end else if (kind != KIND_RST && nmi_pending) begin
                    nmi_clear      = 1'b1;
                    vec_sel_nmi_nx = 1'b1;
                end
            end
            ST_VLO:  if (bus.rdy) state_nx = ST_VHI;
            ST_VHI:  if (bus.rdy) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        vec_nx = IRQ_VEC;
        if (vec_sel_nmi_nx || kind_nx == KIND_NMI) begin
            vec_nx = NMI_VEC;
        end else if (kind_nx == KIND_RST) begin
            vec_nx = RST_VEC;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            kind        <= KIND_RST;
            vec_sel_nmi <= 1'b0;
            rst_pending <= 1'b1;
            outs        <= decode_outputs(ST_IDLE, KIND_RST, 16'h0000);
        end else begin
            state       <= state_nx;
            kind        <= kind_nx;
            vec_sel_nmi <= vec_sel_nmi_nx;
            if (state == ST_IDLE && bus.rdy) begin
                rst_pending <= 1'b0;
            end
            outs <= decode_outputs(state_nx, kind_nx, vec_nx);
        end
    end

    assign bus.busy      = outs.busy;
    assign bus.push_pch  = outs.push_pch;
    assign bus.push_pcl  = outs.push_pcl;
    assign bus.push_p    = outs.push_p;
    assign bus.sp_dec    = outs.sp_dec;
    assign bus.rw        = outs.rw;
    assign bus.b_flag    = outs.b_flag;
    assign bus.vec_rd_lo = outs.vec_rd_lo;
    assign bus.vec_rd_hi = outs.vec_rd_hi;
    assign bus.vec_addr  = outs.vec_addr;
    assign bus.set_i     = outs.set_i;
    // done marks only the cycle in which VHI actually retires.
    assign bus.done      = (state == ST_VHI) && bus.rdy && rst_n;
endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - directed self-checking bench for interrupt_sequencer
module tb_interrupt_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    interrupt_sequencer_if bus ();

    interrupt_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // flag order: busy | pch pcl p | sp rw b | vlo vhi seti done
    localparam logic [10:0] F_IDLE   = 11'b0_000_010_0000;
    localparam logic [10:0] F_DUM    = 11'b1_000_010_0000;
    localparam logic [10:0] F_WR_RST = 11'b1_000_110_0000;
    localparam logic [10:0] F_PCH    = 11'b1_100_100_0000;
    localparam logic [10:0] F_PCL    = 11'b1_010_100_0000;
    localparam logic [10:0] F_PSR    = 11'b1_001_100_0000;
    localparam logic [10:0] F_VLO    = 11'b1_000_010_1000;
    localparam logic [10:0] F_VHI    = 11'b1_000_010_0111;
    localparam logic [10:0] F_B      = 11'b0_000_001_0000;
    localparam logic [10:0] F_DONE   = 11'b0_000_000_0001;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [10:0] ef, input logic [15:0] ea);
        logic [10:0] of;
        of = {bus.busy, bus.push_pch, bus.push_pcl, bus.push_p, bus.sp_dec, bus.rw,
              bus.b_flag, bus.vec_rd_lo, bus.vec_rd_hi, bus.set_i, bus.done};
        checks++;
        assert ({of, bus.vec_addr} === {ef, ea}) else begin
            failures++;
            $error("FAIL %s flags=%b addr=%h expected flags=%b addr=%h", tag, of, bus.vec_addr, ef, ea);
        end
    endtask

    // Caller sets the start condition; the first edge starts the sequence.
    task automatic run7(input string tag, input logic b, input logic is_rst, input logic [15:0] va);
        logic [10:0] bb;
        bb = b ? F_B : 11'b0;
        step();
        bus.insn_boundary = 1'b0;
        bus.brk = 1'b0;
        bus.irq = 1'b1;
        bus.i_flag = 1'b1;
        chk({tag, "_dum1"}, F_DUM | bb, 16'h0000);
        step(); chk({tag, "_dum2"}, F_DUM | bb, 16'h0000);
        step(); chk({tag, "_pch"}, (is_rst ? F_WR_RST : F_PCH) | bb, 16'h0000);
        step(); chk({tag, "_pcl"}, (is_rst ? F_WR_RST : F_PCL) | bb, 16'h0000);
        step(); chk({tag, "_psr"}, (is_rst ? F_WR_RST : F_PSR) | bb, 16'h0000);
        step(); chk({tag, "_vlo"}, F_VLO | bb, va);
        step(); chk({tag, "_vhi"}, F_VHI | bb, va + 16'd1);
        step(); chk({tag, "_idle"}, F_IDLE, 16'h0000);
    endtask

    initial begin
        bus.rdy = 1'b1;
        bus.nmi = 1'b1;
        bus.irq = 1'b1;
        bus.i_flag = 1'b1;
        bus.insn_boundary = 1'b0;
        bus.brk = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        chk("reset", F_IDLE, 16'h0000);

        rst_n = 1'b1;
        run7("rst", 1'b0, 1'b1, 16'hFFFC);

        bus.irq = 1'b0; bus.i_flag = 1'b1; bus.insn_boundary = 1'b1;
        step(); chk("irq_masked", F_IDLE, 16'h0000);
        bus.i_flag = 1'b0; bus.insn_boundary = 1'b0;
        step();
        bus.irq = 1'b1; bus.insn_boundary = 1'b1;
        step(); chk("irq_released", F_IDLE, 16'h0000);

        bus.irq = 1'b0; bus.i_flag = 1'b0; bus.insn_boundary = 1'b1;
        run7("irq", 1'b0, 1'b0, 16'hFFFE);

        bus.brk = 1'b1; bus.irq = 1'b0; bus.i_flag = 1'b1; bus.insn_boundary = 1'b1;
        run7("brk", 1'b1, 1'b0, 16'hFFFE);

        bus.nmi = 1'b0; bus.insn_boundary = 1'b1;
        run7("nmi", 1'b0, 1'b0, 16'hFFFA);
        bus.nmi = 1'b1;
        step();

        bus.brk = 1'b1; bus.insn_boundary = 1'b1;
        step();
        bus.brk = 1'b0; bus.insn_boundary = 1'b0;
        chk("hj_dum1", F_DUM | F_B, 16'h0000);
        step(); chk("hj_dum2", F_DUM | F_B, 16'h0000);
        step(); chk("hj_pch", F_PCH | F_B, 16'h0000);
        step(); chk("hj_pcl", F_PCL | F_B, 16'h0000);
        bus.nmi = 1'b0;
        step(); chk("hj_psr", F_PSR | F_B, 16'h0000);
        step(); chk("hj_vlo", F_VLO | F_B, 16'hFFFA);
        step(); chk("hj_vhi", F_VHI | F_B, 16'hFFFB);
        step(); chk("hj_idle", F_IDLE, 16'h0000);
        bus.insn_boundary = 1'b1;
        step();
        step(); chk("hj_no_second_nmi", F_IDLE, 16'h0000);
        bus.insn_boundary = 1'b0; bus.nmi = 1'b1;
        step();

        bus.irq = 1'b0; bus.i_flag = 1'b0; bus.insn_boundary = 1'b1;
        step();
        bus.irq = 1'b1; bus.i_flag = 1'b1; bus.insn_boundary = 1'b0;
        chk("st_dum1", F_DUM, 16'h0000);
        step(); chk("st_dum2", F_DUM, 16'h0000);
        bus.rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk("st_dum2_hold", F_DUM, 16'h0000);
        end
        bus.rdy = 1'b1;
        step(); chk("st_pch", F_PCH, 16'h0000);
        bus.rdy = 1'b0;
        step(); chk("st_pcl", F_PCL, 16'h0000);
        step(); chk("st_psr", F_PSR, 16'h0000);
        step(); chk("st_vlo", F_VLO & ~F_DONE, 16'hFFFE);
        bus.rdy = 1'b1;
        step(); chk("st_vhi", F_VHI, 16'hFFFF);
        step(); chk("st_idle", F_IDLE, 16'h0000);

        bus.irq = 1'b0; bus.i_flag = 1'b0; bus.insn_boundary = 1'b1;
        step();
        bus.irq = 1'b1; bus.i_flag = 1'b1; bus.insn_boundary = 1'b0;
        step(); step(); step();
        step(); chk("rs_psr", F_PSR, 16'h0000);
        rst_n = 1'b0;
        step(); chk("rs_abort", F_IDLE, 16'h0000);
        step(); chk("rs_hold", F_IDLE, 16'h0000);
        rst_n = 1'b1;
        step(); chk("rs_dum1", F_DUM, 16'h0000);
        step(); chk("rs_dum2", F_DUM, 16'h0000);
        step(); chk("rs_pch", F_WR_RST, 16'h0000);
        step(); chk("rs_pcl", F_WR_RST, 16'h0000);
        step(); chk("rs_psr2", F_WR_RST, 16'h0000);
        step(); chk("rs_vlo", F_VLO, 16'hFFFC);
        step();
        bus.rdy = 1'b0;
        #1; chk("rs_vhi_stall", F_VHI & ~F_DONE, 16'hFFFD);
        step(); chk("rs_vhi_hold", F_VHI & ~F_DONE, 16'hFFFD);
        bus.rdy = 1'b1;
        #1; chk("rs_vhi_done", F_VHI, 16'hFFFD);
        step(); chk("rs_idle", F_IDLE, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 SHALL have parameter NMI_VEC, default 16'hFFFA, meaning NMI vector address.
REQ-002 SHALL have parameter RST_VEC, default 16'hFFFC, meaning reset vector address.
REQ-003 SHALL have parameter IRQ_VEC, default 16'hFFFE, meaning IRQ/BRK vector address.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 rdy  input  1  high = advance; low = stall read cycles.
REQ-007 nmi  input  1  active-low NMI pin; falling edge requests.
REQ-008 irq  input  1  active-low IRQ pin; level requests.
REQ-009 i_flag  input  1  interrupt-disable flag from status.
REQ-010 insn_boundary  input  1  decoder at opcode-fetch cycle; sample point for requests.
REQ-011 brk  input  1  decoder has BRK opcode, valid with insn_boundary.
REQ-012 busy  output  1  sequence in progress; decoder holds off.
REQ-013 push_pch, push_pcl, push_p  output  1 each  stack-write strobes, one cycle each.
REQ-014 sp_dec  output  1  decrement stack pointer this cycle.
REQ-015 rw  output  1  1 = read, 0 = write.
REQ-016 b_flag  output  1  B bit value for pushed status.
REQ-017 vec_rd_lo, vec_rd_hi  output  1 each  vector byte fetch strobes.
REQ-018 vec_addr  output  16  vector byte address, valid with vec_rd_lo/hi, else 0.
REQ-019 set_i  output  1  set I flag, one cycle.
REQ-020 done  output  1  one-cycle pulse on final cycle.

Function
REQ-021 SHALL implement states IDLE, DUM1, DUM2, PCH, PCL, PSR, VLO, VHI; sequence order fixed; 7 cycles DUM1..VHI when rdy high.
REQ-022 From IDLE, start SHALL occur at insn_boundary=1 with priority: pending reset > latched NMI > brk > (irq low and i_flag=0); else stay IDLE.
REQ-023 Kind (RST/NMI/BRK/IRQ) SHALL be latched at start and drive b_flag=1 only for BRK, 0 otherwise.
REQ-024 PCH, PCL, PSR SHALL each assert sp_dec and the matching push strobe; rw=0 except kind RST, where rw=1 and push strobes stay 0 (sp_dec still asserted).
REQ-025 VLO SHALL drive vec_rd_lo, vec_addr=vector; VHI SHALL drive vec_rd_hi, vec_addr=vector+1, set_i=1, done=1, then return to IDLE.
REQ-026 NMI edge detector SHALL register nmi, latch request on 1->0 transition, clear latch when an NMI sequence enters VLO.
REQ-027 NMI hijack: NMI latched while IRQ/BRK sequence is in DUM1..PSR SHALL select NMI_VEC at VLO and clear the latch; b_flag unchanged.
REQ-028 NMI edge arriving during VLO/VHI SHALL stay latched and start a new sequence at next insn_boundary.
REQ-029 rdy=0 SHALL freeze state in IDLE, DUM1, DUM2, VLO, VHI; write states PCH, PCL, PSR SHALL advance regardless of rdy.
REQ-030 Stalled strobes SHALL hold their level; done pulses only in the cycle VHI advances.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 irq is level-sensitive, not latched; irq released before insn_boundary produces no sequence.

Reset
REQ-033 rst_n=0 SHALL force IDLE, clear NMI latch, set reset-pending, all outputs 0 except rw=1.
REQ-034 Reset mid-sequence SHALL abort immediately, without done.
REQ-035 First cycle after release SHALL start RST sequence without waiting for insn_boundary; reset-pending clears at start.

Structure
REQ-036 State enum, kind enum and default vector constants SHALL live in shared package tinymos6502_pkg.
REQ-037 NMI edge detection/latch SHALL be sub-module nmi_edge_detect.

Verification
REQ-038 Release rst_n, rdy=1 -> 7 cycles busy, rw=1 throughout, sp_dec x3, vec_addr FFFC then FFFD, done on cycle 7.
REQ-039 irq=0, i_flag=0, insn_boundary pulse -> pushes PCH/PCL/P with rw=0, b_flag=0, vectors FFFE/FFFF, set_i at VHI.
REQ-040 brk=1 with irq=0 and i_flag=1 -> BRK sequence, b_flag=1, vector FFFE.
REQ-041 nmi falls during BRK state PCL -> VLO fetches FFFA, b_flag stays 1, no second NMI sequence.
REQ-042 rdy=0 for 3 cycles in DUM2 and in PCL -> DUM2 stalls 3 cycles, PCL does not; total 10 cycles.
REQ-043 rst_n=0 during PSR of IRQ sequence -> IDLE next cycle, no done, RST sequence after release.
